// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin Wishbone B3 arbiter, WB_PORTS masters onto one slave port.
// Whole bus cycles (CYC high to CYC low) are granted; the granted master is routed
// combinationally. Define WB_ARB_TIMEOUT_EN to add the hung-cycle watchdog (ERR/HOLD).
module wb_port_arbiter #(
    parameter int unsigned WB_PORTS = 3,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,
    input  logic [WB_PORTS*32-1:0] wbs_adr_i,
    input  logic [WB_PORTS*32-1:0] wbs_dat_i,
    input  logic [WB_PORTS*4-1:0]  wbs_sel_i,
    input  logic [WB_PORTS*3-1:0]  wbs_cti_i,
    input  logic [WB_PORTS*2-1:0]  wbs_bte_i,
    input  logic [WB_PORTS-1:0]    wbs_we_i,
    input  logic [WB_PORTS-1:0]    wbs_stb_i,
    input  logic [WB_PORTS-1:0]    wbs_cyc_i,
    output logic [WB_PORTS*32-1:0] wbs_dat_o,
    output logic [WB_PORTS-1:0]    wbs_ack_o,
    output logic [WB_PORTS-1:0]    wbs_err_o,
    output logic [31:0]            wbm_adr_o,
    output logic [31:0]            wbm_dat_o,
    output logic [3:0]             wbm_sel_o,
    output logic [2:0]             wbm_cti_o,
    output logic [1:0]             wbm_bte_o,
    output logic                   wbm_we_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_cyc_o,
    input  logic [31:0]            wbm_dat_i,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_err_i,
    output logic [WB_PORTS-1:0]    grant_o,
    output logic                   busy_o
);

    localparam int unsigned IW = $clog2(WB_PORTS);

    if (WB_PORTS < 2 || WB_PORTS > 8) begin : g_bad_ports
        $error("wb_port_arbiter: WB_PORTS must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_port_arbiter: TIMEOUT must be 1..65535");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StGrant, StErr, StHold} state_e;
    logic [15:0]   r_wd;
`else
    typedef enum logic [1:0] {StIdle, StGrant} state_e;
`endif

    state_e        r_state;
    logic [WB_PORTS-1:0] r_grant;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_gidx;
    logic          w_found;
    logic [IW-1:0] w_next;
    logic [IW-1:0] w_idx;
    logic          w_gcyc;
    logic          w_gstb;

    assign w_gcyc  = wbs_cyc_i[r_gidx];
    assign w_gstb  = wbs_stb_i[r_gidx];
    assign grant_o = r_grant;
    assign busy_o  = (r_state != StIdle);

    // Round-robin search: first requester after the last granted port, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_next  = r_last;
        w_idx   = '0;
        for (int unsigned i = 1; i <= WB_PORTS; i++) begin
            w_idx = IW'((32'(r_last) + i) % WB_PORTS);
            if (!w_found && wbs_cyc_i[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    // Arbitration FSM with registered one-hot grant and watchdog.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= IW'(WB_PORTS - 1);
            r_gidx  <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            r_wd    <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state <= StGrant;
                        r_grant <= {{(WB_PORTS-1){1'b0}}, 1'b1} << w_next;
                        r_last  <= w_next;
                        r_gidx  <= w_next;
                    end
                end
                StGrant: begin
                    if (!w_gcyc) begin
                        r_state <= StIdle;
                        r_grant <= '0;
`ifdef WB_ARB_TIMEOUT_EN
                        r_wd    <= '0;
                    end else if (w_gstb && !wbm_ack_i && !wbm_err_i) begin
                        if (r_wd == 16'(TIMEOUT - 1)) begin
                            r_state <= StErr;
                            r_wd    <= '0;
                        end else begin
                            r_wd <= r_wd + 16'd1;
                        end
                    end else begin
                        r_wd <= '0;
`endif
                    end
                end
`ifdef WB_ARB_TIMEOUT_EN
                StErr: begin
                    r_state <= StHold;
                end
                StHold: begin
                    if (!w_gcyc) begin
                        r_state <= StIdle;
                        r_grant <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Combinational routing of the granted master to the slave and back.
    always_comb begin
        wbs_dat_o = {WB_PORTS{wbm_dat_i}};
        wbs_ack_o = '0;
        wbs_err_o = '0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_sel_o = '0;
        wbm_cti_o = '0;
        wbm_bte_o = '0;
        wbm_we_o  = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_cyc_o = 1'b0;
        if (r_state != StIdle) begin
            wbm_adr_o = wbs_adr_i[32'(r_gidx)*32 +: 32];
            wbm_dat_o = wbs_dat_i[32'(r_gidx)*32 +: 32];
            wbm_sel_o = wbs_sel_i[32'(r_gidx)*4 +: 4];
            wbm_cti_o = wbs_cti_i[32'(r_gidx)*3 +: 3];
            wbm_bte_o = wbs_bte_i[32'(r_gidx)*2 +: 2];
            wbm_we_o  = wbs_we_i[r_gidx];
        end
        if (r_state == StGrant) begin
            // CYC follows the master so release drops it in the same cycle.
            wbm_cyc_o         = w_gcyc;
            wbm_stb_o         = w_gstb & w_gcyc;
            wbs_ack_o[r_gidx] = wbm_ack_i;
            wbs_err_o[r_gidx] = wbm_err_i;
        end
`ifdef WB_ARB_TIMEOUT_EN
        // Abort pulse; any late slave ACK is swallowed.
        if (r_state == StErr) begin
            wbs_err_o[r_gidx] = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (3 ports, TIMEOUT=8).
module tb_wb_port_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP*32-1:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [NP*4-1:0]  wbs_sel_i;
    logic [NP*3-1:0]  wbs_cti_i;
    logic [NP*2-1:0]  wbs_bte_i;
    logic [NP-1:0]    wbs_we_i, wbs_stb_i, wbs_cyc_i, wbs_ack_o, wbs_err_o, grant_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]       wbm_sel_o;
    logic [2:0]       wbm_cti_o;
    logic [1:0]       wbm_bte_o;
    logic             wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i, wbm_err_i, busy_o;

    wb_port_arbiter #(.WB_PORTS(NP), .TIMEOUT(TO)) dut (
        .wb_clk    (clk),
        .wb_rst_n  (rst_n),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_cti_i (wbs_cti_i),
        .wbs_bte_i (wbs_bte_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_cti_o (wbm_cti_o),
        .wbm_bte_o (wbm_bte_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o)
    );

    typedef struct {
        bit         rst;     // pulse reset before this vector
        logic [2:0] cyc;     // CYC (and STB) per port
        logic       ack;
        logic       err;
        logic [2:0] cti;
        logic [2:0] e_grant;
        logic       e_cyc;
        logic [2:0] e_ack;
        logic [2:0] e_err;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur;
    vec_t exp_v;

    int checks = 0;
    int failures = 0;

    logic [2:0] e_grant, e_ack, e_err;
    logic       e_cyc;

    function automatic logic [31:0] port_adr(int p);
        return 32'hA000_0000 + 32'(p) * 32'h10;
    endfunction

    function automatic logic [3:0] port_sel(int p);
        return 4'(1 << p);
    endfunction

    function automatic int gidx(logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic void add(bit rst, logic [2:0] cyc, logic ack, logic err, logic [2:0] cti,
                                logic [2:0] eg, logic ec, logic [2:0] ea, logic [2:0] ee,
                                logic eb);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.err = err; v.cti = cti;
        v.e_grant = eg; v.e_cyc = ec; v.e_ack = ea; v.e_err = ee; v.e_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [2:0] cyc, logic [2:0] stb, logic ack, logic err, logic [2:0] cti);
        wbs_cyc_i = cyc;
        wbs_stb_i = stb;
        wbm_ack_i = ack;
        wbm_err_i = err;
        wbs_cti_i = {3{cti}};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_vec(int i, vec_t e);
        int g;
        g = gidx(e.e_grant);
        check($sformatf("v%0d.grant", i), 96'(grant_o), 96'(e.e_grant));
        check($sformatf("v%0d.wbm_cyc", i), 96'(wbm_cyc_o), 96'(e.e_cyc));
        check($sformatf("v%0d.wbm_stb", i), 96'(wbm_stb_o), 96'(e.e_cyc));
        check($sformatf("v%0d.ack", i), 96'(wbs_ack_o), 96'(e.e_ack));
        check($sformatf("v%0d.err", i), 96'(wbs_err_o), 96'(e.e_err));
        check($sformatf("v%0d.busy", i), 96'(busy_o), 96'(e.e_busy));
        check($sformatf("v%0d.adr", i), 96'(wbm_adr_o), 96'((g >= 0) ? port_adr(g) : 32'h0));
        check($sformatf("v%0d.sel", i), 96'(wbm_sel_o), 96'((g >= 0) ? port_sel(g) : 4'h0));
        check($sformatf("v%0d.cti", i), 96'(wbm_cti_o), 96'((g >= 0) ? e.cti : 3'b000));
        check($sformatf("v%0d.rdata", i), wbs_dat_o, {3{wbm_dat_i}});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < int'(NP); p++) begin
            wbs_adr_i[p*32 +: 32] = port_adr(p);
            wbs_dat_i[p*32 +: 32] = 32'h5000_0000 + 32'(p);
            wbs_sel_i[p*4 +: 4]   = port_sel(p);
            wbs_bte_i[p*2 +: 2]   = 2'(p);
        end
        wbs_we_i  = 3'b101;
        wbm_dat_i = 32'hCAFE_0000;

        // Reset with all masters requesting: everything must stay quiet.
        drive(3'b111, 3'b111, 1'b1, 1'b1, 3'b010);
        #2;
        check("rst.grant", 96'(grant_o), 96'(0));
        check("rst.busy", 96'(busy_o), 96'(0));
        check("rst.wbm_cyc", 96'(wbm_cyc_o), 96'(0));
        check("rst.ack", 96'(wbs_ack_o), 96'(0));
        check("rst.err", 96'(wbs_err_o), 96'(0));
        check("rst.adr", 96'(wbm_adr_o), 96'(0));

        //   rst cyc    ack err cti     grant  cyc ack    err    busy
        // Port 1 incrementing burst, 4 ACKs.
        add(1, 3'b010, 0, 0, 3'b010, 3'b000, 0, 3'b000, 3'b000, 0);
        add(0, 3'b010, 1, 0, 3'b010, 3'b010, 1, 3'b010, 3'b000, 1);
        add(0, 3'b010, 1, 0, 3'b010, 3'b010, 1, 3'b010, 3'b000, 1);
        add(0, 3'b010, 1, 0, 3'b010, 3'b010, 1, 3'b010, 3'b000, 1);
        add(0, 3'b010, 1, 0, 3'b111, 3'b010, 1, 3'b010, 3'b000, 1);
        add(0, 3'b000, 0, 0, 3'b000, 3'b010, 0, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        // All three request from reset: order 0, 1, 2 with an idle cycle between.
        add(1, 3'b111, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 3'b000, 3'b001, 1, 3'b001, 3'b000, 1);
        add(0, 3'b110, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b000, 1);
        add(0, 3'b110, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        add(0, 3'b110, 1, 0, 3'b000, 3'b010, 1, 3'b010, 3'b000, 1);
        add(0, 3'b100, 0, 0, 3'b000, 3'b010, 0, 3'b000, 3'b000, 1);
        add(0, 3'b100, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        add(0, 3'b100, 1, 0, 3'b000, 3'b100, 1, 3'b100, 3'b000, 1);
        add(0, 3'b000, 0, 0, 3'b000, 3'b100, 0, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        // Port 0 releases and re-requests while port 2 waits: port 2 goes first.
        add(1, 3'b001, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        add(0, 3'b101, 1, 0, 3'b000, 3'b001, 1, 3'b001, 3'b000, 1);
        add(0, 3'b100, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b000, 1);
        add(0, 3'b101, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        add(0, 3'b101, 1, 0, 3'b000, 3'b100, 1, 3'b100, 3'b000, 1);
        add(0, 3'b001, 0, 0, 3'b000, 3'b100, 0, 3'b000, 3'b000, 1);
        add(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
        add(0, 3'b001, 0, 1, 3'b000, 3'b001, 1, 3'b000, 3'b001, 1);
        add(0, 3'b000, 0, 0, 3'b000, 3'b001, 0, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            if (cur.rst) do_reset();
            @(posedge clk);
            #1;
            wbm_dat_i = 32'hCAFE_0000 | 32'(i);
            drive(cur.cyc, cur.cyc, cur.ack, cur.err, cur.cti);
            sb.push_back(cur);
            #1;
            exp_v = sb.pop_front();
            check_vec(i, exp_v);
        end

        // Hung slave: port 1 holds CYC/STB, slave never answers until a late ACK.
        do_reset();
        @(posedge clk);
        #1;
        drive(3'b010, 3'b010, 1'b0, 1'b0, 3'b000);
        #1;
        check("wd.k0.grant", 96'(grant_o), 96'(0));
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            drive((k <= 12) ? 3'b010 : 3'b000, (k <= 12) ? 3'b010 : 3'b000, (k == 9), 1'b0,
                  3'b000);
            #1;
`ifdef WB_ARB_TIMEOUT_EN
            e_cyc = (k <= int'(TO));
            e_err = (k == int'(TO) + 1) ? 3'b010 : 3'b000;
            e_ack = 3'b000;
`else
            e_cyc = (k <= 12);
            e_err = 3'b000;
            e_ack = (k == 9) ? 3'b010 : 3'b000;
`endif
            e_grant = (k <= 13) ? 3'b010 : 3'b000;
            check($sformatf("wd.k%0d.grant", k), 96'(grant_o), 96'(e_grant));
            check($sformatf("wd.k%0d.wbm_cyc", k), 96'(wbm_cyc_o), 96'(e_cyc));
            check($sformatf("wd.k%0d.err", k), 96'(wbs_err_o), 96'(e_err));
            check($sformatf("wd.k%0d.ack", k), 96'(wbs_ack_o), 96'(e_ack));
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        @(posedge clk);
        #1;
        drive(3'b010, 3'b010, 1'b0, 1'b0, 3'b010);
        @(posedge clk);
        #1;
        drive(3'b010, 3'b010, 1'b1, 1'b0, 3'b010);
        #1;
        check("arst.pre.grant", 96'(grant_o), 96'(3'b010));
        check("arst.pre.ack", 96'(wbs_ack_o), 96'(3'b010));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.grant", 96'(grant_o), 96'(0));
        check("arst.wbm_cyc", 96'(wbm_cyc_o), 96'(0));
        check("arst.ack", 96'(wbs_ack_o), 96'(0));
        check("arst.busy", 96'(busy_o), 96'(0));
        drive(3'b111, 3'b111, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("arst.first_grant", 96'(grant_o), 96'(3'b001));
        check("arst.first_adr", 96'(wbm_adr_o), 96'(port_adr(0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
